// File: rtl/enemy_motion_ctrl.sv
// Per-frame motion controller for up to 127 bouncing enemies.
// Each slot moves along one axis between configured bounds, reversing at either end.
module enemy_motion_ctrl #(
   parameter int Enemies = 29,
   parameter int CoordW  = 10,
   parameter int SpeedW  = 4
) (
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [6:0]        cfg_idx,
   input  logic [CoordW-1:0] cfg_x,
   input  logic [CoordW-1:0] cfg_y,
   input  logic [CoordW-1:0] cfg_min,
   input  logic [CoordW-1:0] cfg_max,
   input  logic              cfg_axis,
   input  logic              cfg_dir,
   input  logic [SpeedW-1:0] cfg_speed,
   output logic              cfg_err,
   input  logic              start,
   input  logic              pause,
   input  logic              restart,
   input  logic              clear,
   output logic [CoordW-1:0] circleX [Enemies],
   output logic [CoordW-1:0] circleY [Enemies],
   output logic [Enemies-1:0] enable,
   output logic [1:0]        state
);

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] RUN    = 2'b01;
   localparam logic [1:0] PAUSED = 2'b10;

   typedef logic [CoordW-1:0] coord_t;

   coord_t            start_x  [Enemies];
   coord_t            start_y  [Enemies];
   coord_t            lo       [Enemies];
   coord_t            hi       [Enemies];
   logic              axis     [Enemies];
   logic              dir0     [Enemies];
   logic              dir      [Enemies];
   logic [SpeedW-1:0] spd      [Enemies];
   coord_t            nxt_pos  [Enemies];
   logic              nxt_dir  [Enemies];

   function automatic coord_t clamp(input coord_t v, input coord_t lo_b, input coord_t hi_b);
      if (v < lo_b)      clamp = lo_b;
      else if (v > hi_b) clamp = hi_b;
      else               clamp = v;
   endfunction

   // Returns {new_dir, new_pos}; compares are one bit wider so no wrap at either end.
   function automatic logic [CoordW:0] step(input coord_t pos, input logic d,
                                            input coord_t lo_b, input coord_t hi_b,
                                            input logic [SpeedW-1:0] s);
      logic [CoordW:0] p, l, h, sp, sum, diff;
      p    = {1'b0, pos};
      l    = {1'b0, lo_b};
      h    = {1'b0, hi_b};
      sp   = {{(CoordW+1-SpeedW){1'b0}}, s};
      sum  = p + sp;
      diff = p - sp;
      if (s == '0)        step = {d, pos};
      else if (!d) begin
         if (sum >= h)    step = {1'b1, hi_b};
         else             step = {1'b0, sum[CoordW-1:0]};
      end else begin
         if (p <= l + sp) step = {1'b0, lo_b};
         else             step = {1'b1, diff[CoordW-1:0]};
      end
   endfunction

   logic   wr_req, cfg_good, wr_ok, do_reload, do_step;
   coord_t ld_x, ld_y;

   assign cfg_ready = (state == IDLE);
   assign wr_req    = cfg_valid && cfg_ready;
   assign cfg_good  = (cfg_idx < 7'(Enemies)) && (cfg_min <= cfg_max);
   assign wr_ok     = wr_req && cfg_good;
   assign do_reload = restart && (state == RUN || state == PAUSED);
   assign do_step   = (state == RUN) && !restart && !pause;
   assign ld_x      = cfg_axis ? cfg_x : clamp(cfg_x, cfg_min, cfg_max);
   assign ld_y      = cfg_axis ? clamp(cfg_y, cfg_min, cfg_max) : cfg_y;

   always_comb begin
      for (int i = 0; i < Enemies; i++) begin
         logic [CoordW:0] r;
         r          = step(axis[i] ? circleY[i] : circleX[i], dir[i], lo[i], hi[i], spd[i]);
         nxt_dir[i] = r[CoordW];
         nxt_pos[i] = r[CoordW-1:0];
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state   <= IDLE;
         cfg_err <= 1'b0;
         enable  <= '0;
         for (int i = 0; i < Enemies; i++) begin
            circleX[i] <= '0;
            circleY[i] <= '0;
            dir[i]     <= 1'b0;
         end
      end else begin
         cfg_err <= wr_req && !cfg_good;
         if (clear) begin
            state  <= IDLE;
            enable <= '0;
            for (int i = 0; i < Enemies; i++) begin
               circleX[i] <= '0;
               circleY[i] <= '0;
               dir[i]     <= 1'b0;
            end
         end else begin
            case (state)
               IDLE:    if (start && ((|enable) || wr_ok)) state <= RUN;
               RUN:     if (!restart && pause) state <= PAUSED;
               PAUSED:  if (!restart && !pause) state <= RUN;
               default: state <= IDLE;
            endcase
            for (int i = 0; i < Enemies; i++) begin
               if (wr_ok && cfg_idx == 7'(i)) begin
                  enable[i]  <= 1'b1;
                  start_x[i] <= ld_x;
                  start_y[i] <= ld_y;
                  circleX[i] <= ld_x;
                  circleY[i] <= ld_y;
                  lo[i]      <= cfg_min;
                  hi[i]      <= cfg_max;
                  axis[i]    <= cfg_axis;
                  dir0[i]    <= cfg_dir;
                  dir[i]     <= cfg_dir;
                  spd[i]     <= cfg_speed;
               end else if (enable[i] && do_reload) begin
                  circleX[i] <= start_x[i];
                  circleY[i] <= start_y[i];
                  dir[i]     <= dir0[i];
               end else if (enable[i] && do_step) begin
                  dir[i] <= nxt_dir[i];
                  if (axis[i]) circleY[i] <= nxt_pos[i];
                  else         circleX[i] <= nxt_pos[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Bench for enemy_motion_ctrl: config table, bounce sequences, pause/restart, clear and reset.
module tb_enemy_motion_ctrl;
   localparam int N = 29, CW = 10, SW = 4;

   logic frame_clk = 1'b0;
   logic Reset, cfg_valid, cfg_axis, cfg_dir, start, pause, restart, clear;
   logic cfg_ready, cfg_err;
   logic [6:0] cfg_idx;
   logic [CW-1:0] cfg_x, cfg_y, cfg_min, cfg_max;
   logic [SW-1:0] cfg_speed;
   logic [CW-1:0] circleX [N];
   logic [CW-1:0] circleY [N];
   logic [N-1:0] enable;
   logic [1:0] state;

   always #5 frame_clk = ~frame_clk;

   enemy_motion_ctrl #(.Enemies(N), .CoordW(CW), .SpeedW(SW)) dut (
      .frame_clk(frame_clk), .Reset(Reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_min(cfg_min), .cfg_max(cfg_max),
      .cfg_axis(cfg_axis), .cfg_dir(cfg_dir), .cfg_speed(cfg_speed), .cfg_err(cfg_err),
      .start(start), .pause(pause), .restart(restart), .clear(clear),
      .circleX(circleX), .circleY(circleY), .enable(enable), .state(state)
   );

   typedef struct {
      logic [6:0] idx;
      int x, y, mn, mx;
      logic axis, dir;
      int spd;
      logic err;
      int ex, ey;
   } cfg_vec_t;

   typedef struct {
      int slot;
      int x;
      int y;
   } pos_exp_t;

   cfg_vec_t vt [8];
   pos_exp_t sb [$];
   logic [N-1:0] exp_en;
   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic idle_inputs();
      Reset = 0; cfg_valid = 0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_min = '0;
      cfg_max = '0; cfg_axis = 0; cfg_dir = 0; cfg_speed = '0;
      start = 0; pause = 0; restart = 0; clear = 0;
   endtask

   task automatic drive_cfg(input cfg_vec_t v);
      cfg_valid = 1; cfg_idx = v.idx; cfg_x = CW'(v.x); cfg_y = CW'(v.y);
      cfg_min = CW'(v.mn); cfg_max = CW'(v.mx); cfg_axis = v.axis; cfg_dir = v.dir;
      cfg_speed = SW'(v.spd);
   endtask

   task automatic push(input int slot, input int x, input int y);
      pos_exp_t e;
      e.slot = slot; e.x = x; e.y = y;
      sb.push_back(e);
   endtask

   task automatic check_sb(input string tag);
      pos_exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s x[%0d]", tag, e.slot), int'(circleX[e.slot]), e.x);
         check($sformatf("%s y[%0d]", tag, e.slot), int'(circleY[e.slot]), e.y);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //            idx    x    y    min  max  ax    dir   spd err   ex   ey
      vt[0] = '{7'd0,  225, 270, 225, 415, 1'b0, 1'b0, 4, 1'b0, 225, 270};
      vt[1] = '{7'd29, 10,  10,  0,   50,  1'b0, 1'b0, 1, 1'b1, 0,   0};
      vt[2] = '{7'd3,  250, 10,  300, 200, 1'b0, 1'b0, 1, 1'b1, 0,   0};
      vt[3] = '{7'd5,  100, 187, 185, 295, 1'b1, 1'b1, 3, 1'b0, 100, 187};
      vt[4] = '{7'd7,  500, 10,  100, 400, 1'b0, 1'b0, 2, 1'b0, 400, 10};
      vt[5] = '{7'd8,  5,   50,  20,  60,  1'b0, 1'b0, 0, 1'b0, 20,  50};
      vt[6] = '{7'd9,  30,  77,  30,  30,  1'b0, 1'b0, 5, 1'b0, 30,  77};
      vt[7] = '{7'd2,  50,  60,  0,   100, 1'b0, 1'b0, 1, 1'b0, 50,  60};
      exp_en = '0;

      idle_inputs();
      Reset = 1; cfg_valid = 1; start = 1;
      tick(); tick();
      idle_inputs();
      check("reset state", int'(state), 0);
      check("reset cfg_ready", int'(cfg_ready), 1);
      check("reset cfg_err", int'(cfg_err), 0);
      check("reset enable", int'(enable), 0);
      push(0, 0, 0);
      check_sb("reset");

      start = 1; tick(); start = 0;
      check("start with no slots", int'(state), 0);

      for (int i = 0; i < 7; i++) begin
         drive_cfg(vt[i]);
         if (!vt[i].err) begin
            exp_en[vt[i].idx] = 1'b1;
            push(int'(vt[i].idx), vt[i].ex, vt[i].ey);
         end
         tick();
         idle_inputs();
         check($sformatf("cfg%0d err", i), int'(cfg_err), int'(vt[i].err));
         check($sformatf("cfg%0d enable", i), int'(enable), int'(exp_en));
         check_sb($sformatf("cfg%0d", i));
         tick();
         check($sformatf("cfg%0d err pulse", i), int'(cfg_err), 0);
      end

      start = 1; tick(); start = 0;
      check("start state", int'(state), 1);
      push(0, 225, 270);
      check_sb("start");

      for (int k = 1; k <= 49; k++) begin
         push(0, (k <= 47) ? 225 + 4 * k : (k == 48) ? 415 : 411, 270);
         if (k <= 20) push(5, 100, (k == 1) ? 185 : 185 + 3 * (k - 1));
         push(7, (k == 1) ? 400 : 400 - 2 * (k - 1), 10);
         push(8, 20, 50);
         push(9, 30, 77);
         push(1, 0, 0);
         tick();
         check_sb($sformatf("run k=%0d", k));
      end

      pause = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("pause%0d state", k), int'(state), 2);
         check($sformatf("pause%0d x0", k), int'(circleX[0]), 411);
      end
      pause = 0; tick();
      check("unpause state", int'(state), 1);

      restart = 1; tick(); restart = 0;
      check("restart state", int'(state), 1);
      push(0, 225, 270); push(5, 100, 187); push(7, 400, 10);
      check_sb("restart");
      tick();
      push(0, 229, 270); push(5, 100, 185); push(7, 400, 10);
      check_sb("after restart");

      clear = 1; restart = 1; tick(); idle_inputs();
      check("clear+restart state", int'(state), 0);
      check("clear+restart enable", int'(enable), 0);
      push(0, 0, 0); push(5, 0, 0); push(7, 0, 0);
      check_sb("clear");

      drive_cfg(vt[7]); start = 1; tick(); idle_inputs();
      check("cfg+start state", int'(state), 1);
      check("cfg+start enable", int'(enable), 32'h4);
      push(2, 50, 60);
      check_sb("cfg+start");
      clear = 1; tick(); idle_inputs();

      drive_cfg(vt[0]); tick(); idle_inputs();
      start = 1; tick(); start = 0;
      for (int k = 0; k < 19; k++) tick();
      check("pre-reset x0", int'(circleX[0]), 301);
      Reset = 1; start = 1; tick(); idle_inputs();
      check("mid-run reset state", int'(state), 0);
      check("mid-run reset x0", int'(circleX[0]), 0);
      check("mid-run reset enable", int'(enable), 0);
      check("mid-run reset cfg_ready", int'(cfg_ready), 1);
      start = 1; tick(); start = 0;
      check("start after reset", int'(state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
